// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken-branch and data-memory waits,
// plus a memory-wait watchdog. Optional perf counters are enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             idex_mem_read_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             exmem_mem_access_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic             mem_error_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_stall;
  logic load_use;
  logic parked;

  assign mem_stall = exmem_mem_access_i & ~mem_ready_i;
  assign load_use  = idex_mem_read_i & (idex_rt_i != '0) &
                     ((idex_rt_i == id_rs_i) | (id_uses_rt_i & (idex_rt_i == id_rt_i)));
  assign parked    = reset | (state_q == StErr);

  // Branch and load-use are ignored while memory stalls; EX/ID are frozen so they are
  // seen again on the release cycle.
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b1;
    memwb_bubble_o = 1'b0;
    if (parked) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
    end else if (load_use) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        if (!mem_stall) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d    = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StErr: state_d = StErr;
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_error_o = (state_q == StErr);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;
  logic             count_stall, count_flush;

  assign count_stall = (mem_stall | load_use) & ~parked;
  assign count_flush = branch_taken_i & ~mem_stall & ~parked;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (count_stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (count_flush && (flush_count_q != '1))  flush_count_q  <= flush_count_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed steps then random cycles, checked against a
// behavioural model of the hazard priority rules, stall-run watchdog and counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RegW    = 5;
  localparam int unsigned Timeout = 16;
  localparam int unsigned CntW    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [RegW-1:0] id_rs, id_rt, idex_rt;
  logic            id_uses_rt, idex_mem_read, branch_taken, exmem_mem_access, mem_ready;
  logic            pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic            exmem_write, memwb_bubble, mem_error;
  logic [CntW-1:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(
    .REG_W      (RegW),
    .MEM_TIMEOUT(Timeout),
    .CNT_W      (CntW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_uses_rt_i      (id_uses_rt),
    .idex_mem_read_i   (idex_mem_read),
    .idex_rt_i         (idex_rt),
    .branch_taken_i    (branch_taken),
    .exmem_mem_access_i(exmem_mem_access),
    .mem_ready_i       (mem_ready),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .ifid_flush_o      (ifid_flush),
    .idex_write_o      (idex_write),
    .idex_bubble_o     (idex_bubble),
    .exmem_write_o     (exmem_write),
    .memwb_bubble_o    (memwb_bubble),
    .mem_error_o       (mem_error),
    .stall_cycles_o    (stall_cycles),
    .flush_count_o     (flush_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Model state: error flag, length of the current stall run, raw event counts.
  bit m_err = 1'b0;
  int m_run = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  function automatic bit f_stall();
    return exmem_mem_access && !mem_ready;
  endfunction

  function automatic bit f_load_use();
    return idex_mem_read && idex_rt != 0 &&
           (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
  endfunction

  function automatic int sat(input int v);
    return (v > (1 << CntW) - 1) ? (1 << CntW) - 1 : v;
  endfunction

  // Order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble
  function automatic logic [6:0] exp_ctrl();
    logic pc, ifw, fl, idw, bub, exw, mwb;
    pc = 1; ifw = 1; fl = 0; idw = 1; bub = 0; exw = 1; mwb = 0;
    if (reset || m_err) begin
      pc = 0; ifw = 0; idw = 0; exw = 0; fl = 1; bub = 1; mwb = 1;
    end else if (f_stall()) begin
      pc = 0; ifw = 0; idw = 0; exw = 0; mwb = 1;
    end else if (branch_taken) begin
      fl = 1; bub = 1;
    end else if (f_load_use()) begin
      pc = 0; ifw = 0; bub = 1;
    end
    return {pc, ifw, fl, idw, bub, exw, mwb};
  endfunction

  task automatic check_all(input string tag);
    logic [6:0]      ctrl, ectrl;
    logic [CntW-1:0] es, ef;
    ctrl  = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble};
    ectrl = exp_ctrl();
`ifdef HAZ_PERF_CNT_EN
    es = CntW'(sat(m_stalls));
    ef = CntW'(sat(m_flushes));
`else
    es = '0;
    ef = '0;
`endif
    n_checks++;
    assert (ctrl === ectrl) n_pass++;
    else $error("FAIL %s ctrl observed %b expected %b", tag, ctrl, ectrl);
    n_checks++;
    assert (mem_error === m_err) n_pass++;
    else $error("FAIL %s mem_error observed %b expected %b", tag, mem_error, m_err);
    n_checks++;
    assert (stall_cycles === es) n_pass++;
    else $error("FAIL %s stall_cycles observed %0d expected %0d", tag, stall_cycles, es);
    n_checks++;
    assert (flush_count === ef) n_pass++;
    else $error("FAIL %s flush_count observed %0d expected %0d", tag, flush_count, ef);
  endtask

  task automatic model_clock();
    bit st;
    st = f_stall();
    if (reset) begin
      m_err = 0; m_run = 0; m_stalls = 0; m_flushes = 0;
    end else if (!m_err) begin
      if (st || f_load_use()) m_stalls++;
      if (!st && branch_taken) m_flushes++;
      if (st) begin
        m_run++;
        if (m_run >= Timeout) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Inputs are already applied; check mid-cycle, then clock DUT and model together.
  task automatic cyc(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; idex_rt = '0; id_uses_rt = 0; idex_mem_read = 0;
    branch_taken = 0; exmem_mem_access = 0; mem_ready = 1;
  endtask

  initial begin
    reset = 1;
    idle();
    cyc("reset0");
    cyc("reset1");
    reset = 0;
    cyc("idle");

    idex_mem_read = 1; idex_rt = 5; id_rs = 5;
    cyc("load_use");
    idex_mem_read = 0;
    cyc("load_use_done");
    idex_mem_read = 1; idex_rt = 0; id_rs = 0;
    cyc("load_use_r0");
    idex_rt = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1;
    cyc("load_use_rt");
    id_uses_rt = 0;
    cyc("load_use_rt_unused");
    id_uses_rt = 1; branch_taken = 1;
    cyc("branch_over_lu");
    idle();

    exmem_mem_access = 1; mem_ready = 0;
    repeat (3) cyc("mem_wait");
    mem_ready = 1;
    cyc("mem_release");
    idle();
    cyc("after_release");

    branch_taken = 1; exmem_mem_access = 1; mem_ready = 0;
    repeat (2) cyc("branch_in_wait");
    mem_ready = 1;
    cyc("branch_release");
    idle();

    exmem_mem_access = 1; mem_ready = 0;
    repeat (16) cyc("watchdog_run");
    cyc("watchdog_trip");
    mem_ready = 1;
    cyc("watchdog_sticky");
    reset = 1;
    cyc("watchdog_reset");
    reset = 0;
    idle();
    cyc("watchdog_cleared");

    exmem_mem_access = 1; mem_ready = 0;
    cyc("midwait_c1");
    reset = 1;
    cyc("midwait_reset");
    reset = 0; mem_ready = 1;
    cyc("midwait_after");
    mem_ready = 0;
    repeat (15) cyc("restart_run");
    mem_ready = 1;
    cyc("restart_release");
    mem_ready = 0;
    repeat (17) cyc("restart_trip");
    reset = 1;
    cyc("restart_reset");
    reset = 0;

    for (int i = 0; i < 600; i++) begin
      reset            = ($urandom_range(0, 59) == 0);
      id_rs            = RegW'($urandom_range(0, 3));
      id_rt            = RegW'($urandom_range(0, 3));
      idex_rt          = RegW'($urandom_range(0, 3));
      id_uses_rt       = 1'($urandom);
      idex_mem_read    = 1'($urandom);
      branch_taken     = ($urandom_range(0, 3) == 0);
      exmem_mem_access = 1'($urandom);
      mem_ready        = (i % 200 > 150) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cyc("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the write-enable and bubble inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. A memory-wait watchdog flags a hung memory and parks the pipeline.

Parameters:
REG_W, 5, register-specifier width
MEM_TIMEOUT, 16, consecutive memory-stall cycles before error (min 2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
idex_mem_read  in  1  instruction in EX is a load
idex_rt  in  REG_W  destination of load in EX
branch_taken  in  1  EX resolved a taken branch/jump
exmem_mem_access  in  1  instruction in MEM reads or writes data memory
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX load zeros (control cleared)
exmem_write  out  1  EX/MEM load enable
memwb_bubble  out  1  MEM/WB load zeros
mem_error  out  1  sticky watchdog error
stall_cycles  out  CNT_W  perf counter (see Optional Feature)
flush_count  out  CNT_W  perf counter (see Optional Feature)

Behaviour:
- All control outputs are combinational from the state register and the inputs. The state register and counters update on posedge clk.
- States:
  - RUN: normal operation.
  - MEM_WAIT: one or more consecutive memory-stall cycles.
  - ERR: watchdog tripped.
- Derived signals:
  - mem_stall = exmem_mem_access & ~mem_ready.
  - load_use = idex_mem_read & (idex_rt != 0) & ((idex_rt == id_rs) | (id_uses_rt & idex_rt == id_rt)).
- Default outputs: all *_write=1, ifid_flush=0, idex_bubble=0, memwb_bubble=0.
- Priority, highest first:
  1. reset or state ERR: pc_write, ifid_write, idex_write and exmem_write are 0; ifid_flush, idex_bubble and memwb_bubble are 1.
  2. mem_stall: pc_write, ifid_write, idex_write and exmem_write are 0; memwb_bubble is 1; flush and idex_bubble are 0. Branch and load-use are ignored this cycle. They are re-evaluated on the release cycle because the EX/ID contents are frozen.
  3. branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1. Load-use is suppressed because that instruction is wrong-path.
  4. load_use: pc_write=0, ifid_write=0, idex_bubble=1. This lasts exactly one cycle, since the bubble clears idex_mem_read.
- Transitions:
  - RUN→MEM_WAIT when mem_stall; wait_cnt←1.
  - MEM_WAIT stays in MEM_WAIT while mem_stall; wait_cnt increments.
  - MEM_WAIT→RUN when ~mem_stall; wait_cnt←0.
  - MEM_WAIT→ERR when mem_stall and wait_cnt == MEM_TIMEOUT−1.
  - ERR persists until reset.
- Release cycle: the cycle with mem_ready=1 produces default or branch/load-use outputs, so MEM/WB captures the memory result in that cycle.
- Watchdog: with MEM_TIMEOUT=16, the 16th consecutive stall cycle is the last in MEM_WAIT. mem_error=1 from the 17th cycle onward; mem_error=1 iff state==ERR.
- Reset values: state RUN, wait_cnt 0, mem_error 0, counters 0.
- Reset mid-MEM_WAIT aborts the wait. The next cycle is RUN and the output is set by the inputs.
- wait_cnt is $clog2(MEM_TIMEOUT)+1 bits wide and never wraps.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with mem_stall or load_use (no ERR, no reset).
  - flush_count increments on every cycle honouring branch_taken.
  - Both saturate at all-ones.
  - Both clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Test Plan:
- Load-use: idex_mem_read=1, idex_rt=5, id_rs=5 for 1 cycle → pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; idex_rt=0 instead → no stall.
- Branch vs load-use same cycle: branch_taken=1 with load_use true → pc_write=1, ifid_flush=1, idex_bubble=1.
- Memory wait: exmem_mem_access=1, mem_ready=0 for 3 cycles then 1 → 3 cycles with all writes 0 and memwb_bubble=1; release cycle has defaults; state returns to RUN; stall_cycles=3 if HAZ_PERF_CNT_EN.
- Branch during mem wait: branch_taken=1 throughout a 2-cycle stall → no flush while stalled; ifid_flush=1 on the release cycle; flush_count=1.
- Watchdog: mem_stall held 16 cycles → mem_error=0 through cycle 16 and 1 from cycle 17; it stays 1 after mem_ready=1; reset clears it and the next cycle shows defaults.
- Reset mid-wait: assert reset on cycle 2 of a stall → outputs show the reset pattern; after release with mem_stall=0, defaults and wait_cnt restart from 1 on the next stall.
